// File: rtl/open_riscv_soc.sv
// ---------------------------------------------------------------------------
// open_riscv_soc
//   Minimal single-cycle RV32I system: instruction ROM, one core and its
//   integer register file. Each rising clock edge retires one instruction.
//   There is no data memory. Loads, stores, FENCE, SYSTEM/CSR and every
//   other unsupported encoding retire as a NOP.
//
//   Ports (top):
//     clk  in  1  system clock, all state updates on the rising edge
//     rst  in  1  asynchronous active-high reset; clears pc and x0..x31
//
//   Fixed hierarchy used by benches:
//     rom_inst.rom_mem[0:4095]                  32-bit instruction words
//     open_risc_v_inst.regs_inst.regs[0:31]     integer register file
//
//   ROM contents are loaded by the bench through rom_inst.rom_mem.
// ---------------------------------------------------------------------------

// Instruction ROM: 4096 x 32, combinational read.
//   i_addr  in  12  word address (pc[13:2])
//   o_data  out 32  instruction word
module open_riscv_rom (
    input  logic [11:0] i_addr,
    output logic [31:0] o_data
);
    logic [31:0] rom_mem [0:4095];

    assign o_data = rom_mem[i_addr];
endmodule

// Register file: two combinational read ports, one write port.
//   i_clk, i_rst        clock, async active-high reset (clears all entries)
//   i_rs1, i_rs2        read addresses; x0 always reads zero
//   o_rs1_data/o_rs2_data read data (old value during a same-cycle write)
//   i_we, i_rd, i_wd    write enable/address/data; writes to x0 are dropped
module open_riscv_regs (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_we,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_wd
);
    logic [31:0] regs [0:31];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (i_we && (i_rd != 5'd0)) begin
            regs[i_rd] <= i_wd;
        end
    end

    assign o_rs1_data = (i_rs1 == 5'd0) ? 32'h0 : regs[i_rs1];
    assign o_rs2_data = (i_rs2 == 5'd0) ? 32'h0 : regs[i_rs2];
endmodule

// Core: pc register plus combinational decode/execute.
//   i_clk, i_rst   clock, async active-high reset (pc <= 0)
//   o_rom_addr     word address into the ROM (pc[13:2]; wraps at 16 KiB)
//   i_inst         instruction at the current pc
module open_riscv_core (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [11:0] o_rom_addr,
    input  logic [31:0] i_inst
);
    logic [31:0] r_pc;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_pc_plus4;
    logic        w_we;
    logic [31:0] w_wd;
    logic [31:0] w_next_pc;
    logic        w_taken;

    assign w_opcode = i_inst[6:0];
    assign w_rd     = i_inst[11:7];
    assign w_f3     = i_inst[14:12];
    assign w_rs1    = i_inst[19:15];
    assign w_rs2    = i_inst[24:20];
    assign w_f7     = i_inst[31:25];

    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_u = {i_inst[31:12], 12'h000};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    assign w_pc_plus4 = r_pc + 32'd4;
    assign o_rom_addr = r_pc[13:2];

    open_riscv_regs regs_inst (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (w_we),
        .i_rd       (w_rd),
        .i_wd       (w_wd)
    );

    // Shared ALU for OP and OP-IMM; i_alt selects SUB / SRA(I).
    function automatic logic [31:0] alu(input logic [2:0] i_f3, input logic i_alt,
                                        input logic [31:0] i_a, input logic [31:0] i_b);
        logic [31:0] r;
        r = 32'h0;
        case (i_f3)
            3'b000: r = i_alt ? (i_a - i_b) : (i_a + i_b);
            3'b001: r = i_a << i_b[4:0];
            3'b010: r = {31'h0, $signed(i_a) < $signed(i_b)};
            3'b011: r = {31'h0, i_a < i_b};
            3'b100: r = i_a ^ i_b;
            3'b101: r = i_alt ? 32'($signed(i_a) >>> i_b[4:0]) : (i_a >> i_b[4:0]);
            3'b110: r = i_a | i_b;
            default: r = i_a & i_b;
        endcase
        return r;
    endfunction

    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'b000: w_taken = (w_rs1_data == w_rs2_data);
            3'b001: w_taken = (w_rs1_data != w_rs2_data);
            3'b100: w_taken = ($signed(w_rs1_data) <  $signed(w_rs2_data));
            3'b101: w_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
            3'b110: w_taken = (w_rs1_data <  w_rs2_data);
            3'b111: w_taken = (w_rs1_data >= w_rs2_data);
            default: w_taken = 1'b0;
        endcase
    end

    // Decode is strict on funct3/funct7 so reserved encodings fall through
    // to the NOP default (pc+4, no write).
    always_comb begin
        w_we      = 1'b0;
        w_wd      = 32'h0;
        w_next_pc = w_pc_plus4;
        case (w_opcode)
            7'b0110111: begin // LUI
                w_we = 1'b1;
                w_wd = w_imm_u;
            end
            7'b0010111: begin // AUIPC
                w_we = 1'b1;
                w_wd = r_pc + w_imm_u;
            end
            7'b1101111: begin // JAL
                w_we      = 1'b1;
                w_wd      = w_pc_plus4;
                w_next_pc = r_pc + w_imm_j;
            end
            7'b1100111: begin // JALR
                if (w_f3 == 3'b000) begin
                    w_we      = 1'b1;
                    w_wd      = w_pc_plus4;
                    w_next_pc = (w_rs1_data + w_imm_i) & ~32'h1;
                end
            end
            7'b1100011: begin // branches
                if (w_taken) w_next_pc = r_pc + w_imm_b;
            end
            7'b0010011: begin // OP-IMM; shift amount is imm[4:0]
                if ((w_f3 == 3'b001 && w_f7 != 7'b0000000) ||
                    (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000)) begin
                    w_we = 1'b0;
                end else begin
                    w_we = 1'b1;
                    w_wd = alu(w_f3, (w_f3 == 3'b101) && w_f7[5], w_rs1_data, w_imm_i);
                end
            end
            7'b0110011: begin // OP
                if ((w_f7 == 7'b0000000) ||
                    (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    w_we = 1'b1;
                    w_wd = alu(w_f3, w_f7[5], w_rs1_data, w_rs2_data);
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_pc <= 32'h0;
        else       r_pc <= w_next_pc;
    end
endmodule

// Top level: wires ROM to core.
module open_riscv_soc (
    input logic clk,
    input logic rst
);
    logic [11:0] w_rom_addr;
    logic [31:0] w_inst;

    open_riscv_rom rom_inst (
        .i_addr (w_rom_addr),
        .o_data (w_inst)
    );

    open_riscv_core open_risc_v_inst (
        .i_clk      (clk),
        .i_rst      (rst),
        .o_rom_addr (w_rom_addr),
        .i_inst     (w_inst)
    );
endmodule

// File: tb/tb_open_riscv_soc.sv
// Directed bench for open_riscv_soc. Programs are poked into the ROM through
// the fixed hierarchy; registers and pc are probed the same way. Inputs change
// and outputs are sampled on the falling edge.
module tb_open_riscv_soc;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    open_riscv_soc dut (
        .clk (clk),
        .rst (rst)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = 32'h0;
    endtask

    task automatic put(input int addr, input logic [31:0] inst);
        dut.rom_inst.rom_mem[addr >> 2] = inst;
    endtask

    // Holds reset for two cycles and releases it on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Lets n rising edges (n retired instructions) pass.
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] xreg(input int idx);
        return dut.open_risc_v_inst.regs_inst.regs[idx];
    endfunction

    function automatic logic [31:0] pc();
        return dut.open_risc_v_inst.r_pc;
    endfunction

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- tests ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;

        // Test 1: ADDI / ADD, plus reset state
        clear_rom();
        put(32'h00, enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));          // addi x1,x0,5
        put(32'h04, enc_i(32'hFFFFFFFD, 5'd0, 3'b000, 5'd2, 7'b0010011));   // addi x2,x0,-3
        put(32'h08, enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3));           // add x3,x1,x2
        put(32'h0C, enc_j(32'd0, 5'd0));                                    // jal x0,0
        do_reset();
        check_eq("rst_pc", pc(), 32'h0);
        check_eq("rst_x1", xreg(1), 32'h0);
        run(1);
        check_eq("t1_first_pc", pc(), 32'h4);
        check_eq("t1_first_x1", xreg(1), 32'd5);
        run(2);
        check_eq("t1_x1", xreg(1), 32'd5);
        check_eq("t1_x2", xreg(2), 32'hFFFFFFFD);
        check_eq("t1_x3", xreg(3), 32'd2);
        run(2);
        check_eq("t1_selfloop_pc", pc(), 32'hC);

        // Test 5 (reuses program 1): reset mid-run, asynchronous
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_pc", pc(), 32'h0);
        check_eq("mid_rst_x1", xreg(1), 32'h0);
        check_eq("mid_rst_x3", xreg(3), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run(2);
        check_eq("rerun_x1", xreg(1), 32'd5);
        check_eq("rerun_x2", xreg(2), 32'hFFFFFFFD);
        check_eq("rerun_x3_pending", xreg(3), 32'h0);
        run(1);
        check_eq("rerun_x3", xreg(3), 32'd2);

        // Test 2: LUI / SUB / SRAI / SRLI / SLT / SLTU / XORI / SLTIU
        rst = 1'b1;
        clear_rom();
        put(32'h00, enc_u(20'h80000, 5'd1, 7'b0110111));                    // lui x1,0x80000
        put(32'h04, enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd2));           // sub x2,x0,x1
        put(32'h08, enc_i({20'h0, 7'b0100000, 5'd4}, 5'd1, 3'b101, 5'd3, 7'b0010011)); // srai x3,x1,4
        put(32'h0C, enc_r(7'b0000000, 5'd0, 5'd1, 3'b010, 5'd4));           // slt x4,x1,x0
        put(32'h10, enc_r(7'b0000000, 5'd0, 5'd1, 3'b011, 5'd5));           // sltu x5,x1,x0
        put(32'h14, enc_i(32'd4, 5'd1, 3'b101, 5'd6, 7'b0010011));          // srli x6,x1,4
        put(32'h18, enc_i(32'hFFFFFFFF, 5'd1, 3'b100, 5'd7, 7'b0010011));   // xori x7,x1,-1
        put(32'h1C, enc_i(32'hFFFFFFFF, 5'd1, 3'b011, 5'd8, 7'b0010011));   // sltiu x8,x1,-1
        do_reset();
        run(8);
        check_eq("t2_lui", xreg(1), 32'h80000000);
        check_eq("t2_sub", xreg(2), 32'h80000000);
        check_eq("t2_srai", xreg(3), 32'hF8000000);
        check_eq("t2_slt", xreg(4), 32'd1);
        check_eq("t2_sltu", xreg(5), 32'd0);
        check_eq("t2_srli", xreg(6), 32'h08000000);
        check_eq("t2_xori", xreg(7), 32'h7FFFFFFF);
        check_eq("t2_sltiu", xreg(8), 32'd1);

        // Test 3: branches (blt taken skips, bltu not taken)
        rst = 1'b1;
        clear_rom();
        put(32'h00, enc_i(32'hFFFFFFFF, 5'd0, 3'b000, 5'd1, 7'b0010011));   // addi x1,x0,-1
        put(32'h04, enc_i(32'd1, 5'd0, 3'b000, 5'd2, 7'b0010011));          // addi x2,x0,1
        put(32'h08, enc_b(32'd8, 5'd2, 5'd1, 3'b100));                      // blt x1,x2,+8
        put(32'h0C, enc_i(32'd9, 5'd0, 3'b000, 5'd3, 7'b0010011));          // addi x3,x0,9 (skipped)
        put(32'h10, enc_b(32'd8, 5'd2, 5'd1, 3'b110));                      // bltu x1,x2,+8
        put(32'h14, enc_i(32'd7, 5'd0, 3'b000, 5'd4, 7'b0010011));          // addi x4,x0,7
        put(32'h18, enc_i(32'd1, 5'd0, 3'b000, 5'd5, 7'b0010011));          // addi x5,x0,1
        do_reset();
        run(3);
        check_eq("t3_blt_target", pc(), 32'h10);
        run(1);
        check_eq("t3_bltu_fallthru", pc(), 32'h14);
        run(2);
        check_eq("t3_skipped_x3", xreg(3), 32'h0);
        check_eq("t3_x4", xreg(4), 32'd7);
        check_eq("t3_x5", xreg(5), 32'd1);
        check_eq("t3_pc", pc(), 32'h1C);

        // Test 4: JAL / JALR (target low bit cleared), x0 write discarded
        rst = 1'b1;
        clear_rom();
        put(32'h10, enc_j(32'd12, 5'd1));                                   // jal x1,+12
        put(32'h14, enc_i(32'd7, 5'd0, 3'b000, 5'd0, 7'b0010011));          // addi x0,x0,7
        put(32'h18, enc_i(32'd3, 5'd0, 3'b000, 5'd6, 7'b0010011));          // addi x6,x0,3
        put(32'h1C, enc_i(32'd1, 5'd1, 3'b000, 5'd7, 7'b1100111));          // jalr x7,1(x1)
        do_reset();
        run(5);
        check_eq("t4_jal_link", xreg(1), 32'h14);
        check_eq("t4_jal_pc", pc(), 32'h1C);
        run(1);
        check_eq("t4_jalr_pc", pc(), 32'h14);
        check_eq("t4_jalr_link", xreg(7), 32'h20);
        run(2);
        check_eq("t4_x0", xreg(0), 32'h0);
        check_eq("t4_x6", xreg(6), 32'd3);
        check_eq("t4_loop_pc", pc(), 32'h1C);

        // Test 6: AUIPC, LUI+ADDI, unsupported encodings as NOP
        rst = 1'b1;
        clear_rom();
        put(32'h04, enc_u(20'h00001, 5'd9, 7'b0010111));                    // auipc x9,1
        put(32'h08, enc_u(20'h12345, 5'd10, 7'b0110111));                   // lui x10,0x12345
        put(32'h0C, enc_i(32'h678, 5'd10, 3'b000, 5'd10, 7'b0010011));      // addi x10,x10,0x678
        put(32'h10, enc_i(32'h300, 5'd0, 3'b001, 5'd11, 7'b1110011));       // csrrw x11,0x300,x0
        put(32'h14, enc_i(32'h0, 5'd0, 3'b010, 5'd12, 7'b0000011));         // lw x12,0(x0)
        put(32'h18, enc_r(7'b0000001, 5'd10, 5'd10, 3'b000, 5'd13));        // mul x13 (unsupported)
        do_reset();
        run(7);
        check_eq("t6_auipc", xreg(9), 32'h00001004);
        check_eq("t6_lui_addi", xreg(10), 32'h12345678);
        check_eq("t6_csr_nop", xreg(11), 32'h0);
        check_eq("t6_load_nop", xreg(12), 32'h0);
        check_eq("t6_mul_nop", xreg(13), 32'h0);
        check_eq("t6_pc", pc(), 32'h1C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
